// File: rtl/led_counter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_counter_ctrl: switch sync/debounce, command FSM, prescaled LED    |
// | counter.  Rev 1.0                                                     |
// +----------------------------------------------------------------------+
module led_counter_ctrl #(
  parameter int BITS      = 4,
  parameter int LOG2DELAY = 26,
  parameter int DEB_BITS  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  output logic [7:0] led
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STEP  = 2'd2;
  localparam logic [1:0] CLEAR = 2'd3;

  localparam logic [DEB_BITS-1:0]  DEB_MAX   = '1;
  localparam logic [LOG2DELAY-1:0] PRESC_ALL = '1;
  localparam logic [BITS-1:0]      CNT_MAX   = '1;

  logic [7:0]           sw_meta;
  logic [7:0]           sw_s;
  logic [7:0]           sw_s_prev;
  logic [7:0]           sw_d;
  logic [7:2]           sw_d_prev;
  logic [DEB_BITS-1:0]  deb_cnt;
  logic                 deb_load;

  logic [LOG2DELAY-1:0] presc;
  logic [LOG2DELAY-1:0] presc_mask;
  logic                 rate_chg;
  logic                 tick;

  logic                 step_p;
  logic                 clear_p;
  logic [1:0]           state;
  logic [1:0]           state_nx;
  logic                 advance;
  logic                 running;

  logic [BITS-1:0]      count;
  logic [3:0]           count_vis;
  logic                 wrap;
  logic                 toggle;

  // Load only once sw_s has held still for the full window, including this cycle.
  assign deb_load = (deb_cnt == DEB_MAX) && (sw_s == sw_s_prev) && (sw_d != sw_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta   <= 8'h00;
      sw_s      <= 8'h00;
      sw_s_prev <= 8'h00;
      sw_d      <= 8'h00;
      sw_d_prev <= 6'h00;
      deb_cnt   <= '0;
    end else begin
      sw_meta   <= sw;
      sw_s      <= sw_meta;
      sw_s_prev <= sw_s;
      if (sw_s != sw_s_prev) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_MAX) begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      if (deb_load) begin
        sw_d <= sw_s;
      end
      sw_d_prev <= sw_d[7:2];
    end
  end

  assign step_p  = sw_d[2] & ~sw_d_prev[2];
  assign clear_p = sw_d[3] & ~sw_d_prev[3];

  // Terminal count 2^(LOG2DELAY-r)-1; shifts to zero (period 1) once r >= LOG2DELAY.
  assign presc_mask = PRESC_ALL >> sw_d[7:4];
  assign rate_chg   = (sw_d[7:4] != sw_d_prev[7:4]);
  assign tick       = (state == RUN) && !rate_chg && (presc == presc_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if ((state != RUN) || rate_chg || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    advance  = 1'b0;
    case (state)
      IDLE: begin
        if (clear_p) begin
          state_nx = CLEAR;
        end else if (step_p) begin
          state_nx = STEP;
        end else if (sw_d[0]) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        advance = tick && !clear_p;
        if (clear_p) begin
          state_nx = CLEAR;
        end else if (!sw_d[0]) begin
          state_nx = IDLE;
        end
      end
      STEP: begin
        advance  = 1'b1;
        state_nx = IDLE;
      end
      CLEAR: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
      count   <= '0;
      wrap    <= 1'b0;
      toggle  <= 1'b0;
    end else begin
      state   <= state_nx;
      running <= (state_nx == RUN);
      if (state == CLEAR) begin
        count  <= '0;
        wrap   <= 1'b0;
        toggle <= 1'b0;
      end else if (advance) begin
        toggle <= ~toggle;
        if (sw_d[1]) begin
          count <= count - 1'b1;
          if (count == '0) begin
            wrap <= 1'b1;
          end
        end else begin
          count <= count + 1'b1;
          if (count == CNT_MAX) begin
            wrap <= 1'b1;
          end
        end
      end
    end
  end

  generate
    if (BITS >= 4) begin : g_vis_wide
      assign count_vis = count[3:0];
    end else begin : g_vis_narrow
      assign count_vis = {{(4-BITS){1'b0}}, count};
    end
  endgenerate

  assign led = {wrap, toggle, sw_d[1], running, count_vis};

endmodule
`default_nettype wire

// File: tb/tb_led_counter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_led_counter_ctrl: directed bench with a behavioural LED model.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_led_counter_ctrl;

  localparam int L2D = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STEP  = 2;
  localparam int M_CLEAR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [7:0] led;

  int total = 0;
  int bad = 0;

  led_counter_ctrl #(
    .BITS      (4),
    .LOG2DELAY (L2D),
    .DEB_BITS  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .led   (led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]      meta;
    logic [4:0][7:0] hist;
    logic [7:0]      swd;
    logic [7:0]      swd_prev;
    int              st;
    int              phase;
    logic [3:0]      count;
    logic            wrap;
    logic            tog;
  } model_t;

  model_t m;
  logic [7:0] exp_led;

  // A switch value is accepted once five consecutive synchronised samples agree.
  function automatic model_t model_step(model_t c, logic [7:0] s_in);
    model_t n;
    logic step_p, clear_p, rate_chg, adv, tick, stable;
    int r, period;
    n        = c;
    step_p   = c.swd[2] & ~c.swd_prev[2];
    clear_p  = c.swd[3] & ~c.swd_prev[3];
    rate_chg = (c.swd[7:4] != c.swd_prev[7:4]);
    r        = int'(c.swd[7:4]);
    period   = (r < L2D) ? (1 << (L2D - r)) : 1;
    adv      = 1'b0;
    tick     = 1'b0;
    n.phase  = 0;
    case (c.st)
      M_IDLE: begin
        if (clear_p) n.st = M_CLEAR;
        else if (step_p) n.st = M_STEP;
        else if (c.swd[0]) n.st = M_RUN;
      end
      M_RUN: begin
        tick = !rate_chg && (c.phase + 1 == period);
        adv  = tick && !clear_p;
        if (clear_p) n.st = M_CLEAR;
        else if (!c.swd[0]) n.st = M_IDLE;
        if (n.st == M_RUN && !rate_chg && !tick) n.phase = c.phase + 1;
      end
      M_STEP: begin
        adv  = 1'b1;
        n.st = M_IDLE;
      end
      default: begin
        n.count = 4'd0;
        n.wrap  = 1'b0;
        n.tog   = 1'b0;
        n.st    = M_IDLE;
      end
    endcase
    if (adv) begin
      n.tog = ~c.tog;
      if (c.swd[1]) begin
        if (c.count == 4'd0) n.wrap = 1'b1;
        n.count = c.count - 4'd1;
      end else begin
        if (c.count == 4'd15) n.wrap = 1'b1;
        n.count = c.count + 4'd1;
      end
    end
    stable = (c.hist[0] == c.hist[1]) && (c.hist[1] == c.hist[2]) &&
             (c.hist[2] == c.hist[3]) && (c.hist[3] == c.hist[4]);
    if (stable) n.swd = c.hist[0];
    n.swd_prev = c.swd;
    n.hist     = {c.hist[3:0], c.meta};
    n.meta     = s_in;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_step(m, sw);
  end

  assign exp_led = {m.wrap, m.tog, m.swd[1], (m.st == M_RUN), m.count};

  always @(negedge clk) begin
    total++;
    if (led !== exp_led) begin
      bad++;
      $display("FAIL model_cmp t=%0t led=%h expected=%h", $time, led, exp_led);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_sw(input logic [7:0] v);
    @(posedge clk);
    #2 sw = v;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_change(output int n);
    logic [3:0] p;
    p = led[3:0];
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((led[3:0] == p) && (n < 100));
    total++;
    if (led[3:0] == p) begin
      bad++;
      $display("FAIL change_timeout got=%h expected=not %h", led[3:0], p);
    end
  endtask

  task automatic wait_count(input logic [3:0] v);
    int n;
    n = 0;
    while ((led[3:0] != v) && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (led[3:0] != v) begin
      bad++;
      $display("FAIL count_timeout got=%h expected=%h", led[3:0], v);
    end
  endtask

  initial begin
    int n;
    wait_neg(3);
    check("reset_led", led, 8'h00);
    rst_n = 1'b1;

    // Free run, up, slowest rate
    set_sw(8'h01);
    wait_neg(12);
    check("run_on", {7'b0, led[4]}, 8'h01);
    wait_count(4'd15);
    check("no_wrap_at_15", {7'b0, led[7]}, 8'h00);
    wait_change(n);
    check("period_r0_a", n[7:0], 8'd16);
    check("wrap_to_0", led[3:0], 4'd0);
    check("wrap_set", {7'b0, led[7]}, 8'h01);
    wait_change(n);
    check("period_r0_b", n[7:0], 8'd16);
    check("count_1", led[3:0], 4'd1);
    check("wrap_sticky", {7'b0, led[7]}, 8'h01);

    // Rate changes
    set_sw(8'h21);
    wait_neg(12);
    wait_change(n);
    wait_change(n);
    check("period_r2", n[7:0], 8'd4);
    set_sw(8'h41);
    wait_neg(12);
    wait_change(n);
    wait_change(n);
    check("period_r4", n[7:0], 8'd1);
    set_sw(8'h91);
    wait_neg(12);
    wait_change(n);
    wait_change(n);
    check("period_r9", n[7:0], 8'd1);

    // Pause with clear, then manual steps
    set_sw(8'h08);
    wait_neg(12);
    check("clear_from_run", led, 8'h00);
    set_sw(8'h00);
    wait_neg(12);
    for (int i = 0; i < 3; i++) begin
      set_sw(8'h04);
      wait_neg(12);
      set_sw(8'h00);
      wait_neg(12);
    end
    check("three_steps", led, 8'h43);
    set_sw(8'h04);
    wait_neg(30);
    check("held_step_once", led, 8'h04);
    set_sw(8'h00);
    wait_neg(12);

    // Step down from zero, then clear
    set_sw(8'h08);
    wait_neg(12);
    set_sw(8'h00);
    wait_neg(12);
    set_sw(8'h02);
    wait_neg(12);
    check("dir_down_idle", led, 8'h20);
    set_sw(8'h06);
    wait_neg(12);
    check("step_down_wrap", led, 8'hEF);
    set_sw(8'h0A);
    wait_neg(12);
    check("clear_after_wrap", led, 8'h20);

    // Bouncing run switch never passes the debouncer
    set_sw(8'h00);
    wait_neg(12);
    check("bounce_base", led, 8'h00);
    for (int i = 0; i < 5; i++) begin
      set_sw(8'h01);
      wait_neg(2);
      set_sw(8'h00);
      wait_neg(2);
    end
    wait_neg(12);
    check("bounce_ignored", led, 8'h00);

    // Clear and step together: clear wins
    set_sw(8'h04);
    wait_neg(12);
    set_sw(8'h00);
    wait_neg(12);
    check("one_step", led, 8'h41);
    set_sw(8'h0C);
    wait_neg(12);
    check("clear_beats_step", led, 8'h00);
    set_sw(8'h00);
    wait_neg(12);

    // Asynchronous reset mid-run
    set_sw(8'h01);
    wait_neg(12);
    check("run_again", {7'b0, led[4]}, 8'h01);
    wait_neg(20);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset", led, 8'h00);
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(3);
    check("no_cmd_before_debounce", led, 8'h00);
    wait_neg(15);
    check("run_after_debounce", {7'b0, led[4]}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
